// File: rtl/eth_decap_core.sv
// eth_decap_core: strips Eth/IPv4/UDP/NetTLP headers from 64-bit RX frames and steers payload to TLP, cmd or pciecfg FIFOs by UDP dport
module eth_decap_core #(
  parameter logic [15:0] udp_dport        = 16'h3000,
  parameter logic [15:0] udp_cmd_port     = 16'h3010,
  parameter logic [15:0] udp_pciecfg_port = 16'h3011
) (
  input  logic        eth_clk,
  input  logic        eth_rst,
  input  logic        eth_rx_tvalid,
  input  logic        eth_rx_tlast,
  input  logic [7:0]  eth_rx_tkeep,
  input  logic [63:0] eth_rx_tdata,
  input  logic        eth_rx_tuser,
  input  logic [47:0] adapter_reg_srcmac,
  input  logic [31:0] adapter_reg_srcip,
  output logic        tlp_wr_en,
  output logic [73:0] tlp_din,
  input  logic        tlp_almost_full,
  output logic        cmd_wr_en,
  output logic [63:0] cmd_din,
  input  logic        cmd_full,
  output logic        pciecfg_wr_en,
  output logic [63:0] pciecfg_din,
  input  logic        pciecfg_full,
  output logic [31:0] rx_pkt_cnt,
  output logic [31:0] rx_drop_cnt
);
  typedef enum logic [2:0] {RX_IDLE, RX_HDR, RX_TLP, RX_CMD, RX_CMD_WAIT, RX_DROP} state_t;
  state_t state, state_d;
  logic [2:0] cnt;
  logic skip;
  logic [47:0] dst_mac;
  logic [15:0] eth_type, dport, dport_off;
  logic [7:0] ver_ihl, proto;
  logic [31:0] daddr;
  logic [63:0] be, cmd_data;
  logic beat, filt_ok, is_tlp, is_cmd, is_cfg, go_ok;
  logic tlp_we, cmd_we, cfg_we, inc_pkt, inc_drop;
  for (genvar i = 0; i < 8; i++) begin : g_be
    assign be[63-8*i -: 8] = eth_rx_tdata[8*i +: 8];
  end
  assign beat      = eth_rx_tvalid && !skip;
  assign dport_off = dport - udp_dport;
  assign is_tlp    = dport >= udp_dport && dport_off < 16'd16;
  assign is_cmd    = dport == udp_cmd_port;
  assign is_cfg    = dport == udp_pciecfg_port;
  assign filt_ok   = (dst_mac == adapter_reg_srcmac || &dst_mac) && eth_type == 16'h0800 &&
                     ver_ihl == 8'h45 && proto == 8'd17 && daddr == adapter_reg_srcip;
  assign go_ok     = eth_rx_tuser && !(is_cfg ? pciecfg_full : cmd_full);
  always_comb begin
    state_d  = state;
    tlp_we   = 1'b0;
    cmd_we   = 1'b0;
    cfg_we   = 1'b0;
    inc_pkt  = 1'b0;
    inc_drop = 1'b0;
    case (state)
      RX_IDLE: if (beat) begin
        state_d  = eth_rx_tlast ? RX_IDLE : RX_HDR;
        inc_drop = eth_rx_tlast;
      end
      RX_HDR: if (beat) begin
        if (eth_rx_tlast) begin
          state_d  = RX_IDLE;
          inc_drop = 1'b1;
        end else if (cnt == 3'd5)
          state_d = (!filt_ok || !(is_tlp || is_cmd || is_cfg) || (is_tlp && tlp_almost_full)) ? RX_DROP :
                    is_tlp ? RX_TLP : RX_CMD;
      end
      RX_TLP: if (beat) begin
        tlp_we  = 1'b1;
        inc_pkt = eth_rx_tlast;
        state_d = eth_rx_tlast ? RX_IDLE : RX_TLP;
      end
      RX_CMD, RX_CMD_WAIT: if (beat) begin
        state_d  = eth_rx_tlast ? RX_IDLE : RX_CMD_WAIT;
        cmd_we   = eth_rx_tlast && go_ok && !is_cfg;
        cfg_we   = eth_rx_tlast && go_ok && is_cfg;
        inc_pkt  = eth_rx_tlast && go_ok;
        inc_drop = eth_rx_tlast && !go_ok;
      end
      RX_DROP: if (beat && eth_rx_tlast) begin
        state_d  = RX_IDLE;
        inc_drop = 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge eth_clk)
    state <= eth_rst ? RX_IDLE : state_d;
  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      skip          <= eth_rx_tvalid ? !eth_rx_tlast : (skip || state != RX_IDLE);
      tlp_wr_en     <= 1'b0;
      tlp_din       <= '0;
      cmd_wr_en     <= 1'b0;
      cmd_din       <= '0;
      pciecfg_wr_en <= 1'b0;
      pciecfg_din   <= '0;
      rx_pkt_cnt    <= '0;
      rx_drop_cnt   <= '0;
    end else begin
      if (eth_rx_tvalid && eth_rx_tlast) skip <= 1'b0;
      tlp_wr_en     <= tlp_we;
      cmd_wr_en     <= cmd_we;
      pciecfg_wr_en <= cfg_we;
      if (tlp_we) tlp_din <= {eth_rx_tlast & !eth_rx_tuser, eth_rx_tlast, eth_rx_tkeep, be[31:0], be[63:32]};
      if (cmd_we) cmd_din <= state == RX_CMD ? be : cmd_data;
      if (cfg_we) pciecfg_din <= state == RX_CMD ? be : cmd_data;
      rx_pkt_cnt  <= rx_pkt_cnt + 32'(inc_pkt);
      rx_drop_cnt <= rx_drop_cnt + 32'(inc_drop);
    end
  end
  always_ff @(posedge eth_clk) begin
    if (beat && state == RX_IDLE) begin
      dst_mac <= be[63:16];
      cnt     <= 3'd1;
    end
    if (beat && state == RX_HDR) begin
      cnt <= cnt + 3'd1;
      if (cnt == 3'd1) {eth_type, ver_ihl} <= be[31:8];
      if (cnt == 3'd2) proto <= be[7:0];
      if (cnt == 3'd3) daddr[31:16] <= be[15:0];
      if (cnt == 3'd4) {daddr[15:0], dport} <= {be[63:48], be[31:16]};
    end
    if (beat && state == RX_CMD) cmd_data <= be;
  end
endmodule

// File: tb/tb_eth_decap_core.sv
// tb_eth_decap_core: randomized scoreboard bench for eth_decap_core against a per-frame reference model
module tb_eth_decap_core;
  localparam logic [47:0] MAC = 48'h02_1A_2B_3C_4D_5E;
  localparam logic [31:0] IP  = 32'hC0A8_0A02;
  localparam logic [15:0] CMD = 16'h3010;
  localparam logic [15:0] CFG = 16'h3011;
  logic eth_clk = 1'b0, eth_rst = 1'b1;
  logic eth_rx_tvalid = 1'b0, eth_rx_tlast = 1'b0, eth_rx_tuser = 1'b0;
  logic [7:0] eth_rx_tkeep = '0;
  logic [63:0] eth_rx_tdata = '0;
  logic tlp_almost_full = 1'b0, cmd_full = 1'b0, pciecfg_full = 1'b0;
  logic tlp_wr_en, cmd_wr_en, pciecfg_wr_en;
  logic [73:0] tlp_din;
  logic [63:0] cmd_din, pciecfg_din;
  logic [31:0] rx_pkt_cnt, rx_drop_cnt;
  logic [73:0] exp_tlp_q[$];
  logic [63:0] exp_cmd_q[$], exp_cfg_q[$];
  int checks = 0, errors = 0, exp_pkt = 0, exp_drop = 0;
  always #5 eth_clk = ~eth_clk;
  eth_decap_core #(.udp_dport(16'h3000), .udp_cmd_port(CMD), .udp_pciecfg_port(CFG)) dut (
    .eth_clk(eth_clk), .eth_rst(eth_rst),
    .eth_rx_tvalid(eth_rx_tvalid), .eth_rx_tlast(eth_rx_tlast), .eth_rx_tkeep(eth_rx_tkeep),
    .eth_rx_tdata(eth_rx_tdata), .eth_rx_tuser(eth_rx_tuser),
    .adapter_reg_srcmac(MAC), .adapter_reg_srcip(IP),
    .tlp_wr_en(tlp_wr_en), .tlp_din(tlp_din), .tlp_almost_full(tlp_almost_full),
    .cmd_wr_en(cmd_wr_en), .cmd_din(cmd_din), .cmd_full(cmd_full),
    .pciecfg_wr_en(pciecfg_wr_en), .pciecfg_din(pciecfg_din), .pciecfg_full(pciecfg_full),
    .rx_pkt_cnt(rx_pkt_cnt), .rx_drop_cnt(rx_drop_cnt)
  );
  task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial forever begin
    @(negedge eth_clk);
    if (tlp_wr_en || cmd_wr_en || pciecfg_wr_en)
      chk("one_write", 74'(tlp_wr_en) + 74'(cmd_wr_en) + 74'(pciecfg_wr_en), 74'd1);
    if (tlp_wr_en) begin
      if (exp_tlp_q.size() == 0) chk("tlp_unexpected_write", 74'(tlp_wr_en), 74'd0);
      else chk("tlp_din", tlp_din, exp_tlp_q.pop_front());
    end
    if (cmd_wr_en) begin
      if (exp_cmd_q.size() == 0) chk("cmd_unexpected_write", 74'(cmd_wr_en), 74'd0);
      else chk("cmd_din", 74'(cmd_din), 74'(exp_cmd_q.pop_front()));
    end
    if (pciecfg_wr_en) begin
      if (exp_cfg_q.size() == 0) chk("cfg_unexpected_write", 74'(pciecfg_wr_en), 74'd0);
      else chk("pciecfg_din", 74'(pciecfg_din), 74'(exp_cfg_q.pop_front()));
    end
  end
  task automatic run_frame(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] vi,
                           input logic [7:0] pr, input logic [31:0] da, input logic [15:0] dp,
                           input int plen, input bit tu, input bit af, input bit cf, input bit pf,
                           input int lim, input int rst_beat, input bit fixp);
    logic [7:0] b[$];
    logic [383:0] hdr;
    logic [7:0] v[8];
    logic [7:0] keep;
    logic [63:0] cmdv;
    int nb;
    bit filt, tlp, ok;
    hdr = {dst, 48'h02_00_00_00_00_99, et, vi, 8'h00, 16'(20 + 8 + plen), 16'($urandom), 16'h4000,
           8'd64, pr, 16'($urandom), 32'hC0A8_0A01, da, 16'($urandom), dp, 16'(8 + plen),
           16'($urandom), 16'($urandom), 32'($urandom)};
    for (int i = 47; i >= 0; i--) b.push_back(hdr[8*i +: 8]);
    for (int i = 0; i < plen; i++) b.push_back(fixp ? 8'(i + 1) : 8'($urandom));
    nb = (b.size() + 7) / 8;
    if (lim > 0 && lim < nb) nb = lim;
    filt = (dst == MAC || dst == 48'hFFFF_FFFF_FFFF) && et == 16'h0800 && vi == 8'h45 && pr == 8'd17 && da == IP;
    tlp  = dp >= 16'h3000 && dp <= 16'h300F;
    if (rst_beat >= 0) begin
      exp_pkt  = 0;
      exp_drop = 0;
    end else if (nb <= 6 || !filt || !(tlp || dp == CMD || dp == CFG) || (tlp && af))
      exp_drop++;
    else if (tlp) begin
      for (int k = 6; k < nb; k++) begin
        for (int i = 0; i < 8; i++) begin
          v[i]    = (8*k + i < b.size()) ? b[8*k + i] : 8'h00;
          keep[i] = 8*k + i < b.size();
        end
        exp_tlp_q.push_back({(k == nb - 1) && !tu, k == nb - 1, keep, v[4], v[5], v[6], v[7], v[0], v[1], v[2], v[3]});
      end
      exp_pkt++;
    end else begin
      ok = tu && !(dp == CMD ? cf : pf);
      for (int i = 0; i < 8; i++) cmdv[63-8*i -: 8] = (48 + i < b.size()) ? b[48 + i] : 8'h00;
      if (ok && dp == CMD) exp_cmd_q.push_back(cmdv);
      if (ok && dp == CFG) exp_cfg_q.push_back(cmdv);
      if (ok) exp_pkt++;
      else exp_drop++;
    end
    tlp_almost_full = af;
    cmd_full        = cf;
    pciecfg_full    = pf;
    for (int k = 0; k < nb; k++) begin
      @(negedge eth_clk);
      if (rst_beat >= 0 && k == rst_beat + 1) begin
        chk("rst_tlp_wr_en", 74'(tlp_wr_en), 74'd0);
        chk("rst_tlp_din", tlp_din, 74'd0);
        chk("rst_cmd_din", 74'(cmd_din), 74'd0);
        chk("rst_pkt_cnt", 74'(rx_pkt_cnt), 74'd0);
      end
      if ($urandom_range(3) == 0) begin
        eth_rx_tvalid = 1'b0;
        eth_rst       = 1'b0;
        @(negedge eth_clk);
      end
      for (int i = 0; i < 8; i++) begin
        eth_rx_tdata[8*i +: 8] = (8*k + i < b.size()) ? b[8*k + i] : 8'h00;
        eth_rx_tkeep[i]        = 8*k + i < b.size();
      end
      eth_rx_tvalid = 1'b1;
      eth_rx_tlast  = k == nb - 1;
      eth_rx_tuser  = (k == nb - 1) ? tu : 1'($urandom);
      eth_rst       = k == rst_beat;
    end
    @(negedge eth_clk);
    eth_rx_tvalid = 1'b0;
    eth_rx_tlast  = 1'b0;
    eth_rst       = 1'b0;
    repeat (2) @(negedge eth_clk);
    chk("rx_pkt_cnt", 74'(rx_pkt_cnt), 74'(exp_pkt));
    chk("rx_drop_cnt", 74'(rx_drop_cnt), 74'(exp_drop));
  endtask
  initial begin
    int kind, fld, lim, plen;
    logic [47:0] dst;
    logic [15:0] et, dp;
    logic [7:0] vi, pr;
    logic [31:0] da;
    repeat (3) @(negedge eth_clk);
    chk("reset_tlp_wr_en", 74'(tlp_wr_en), 74'd0);
    chk("reset_cmd_wr_en", 74'(cmd_wr_en), 74'd0);
    chk("reset_cfg_wr_en", 74'(pciecfg_wr_en), 74'd0);
    chk("reset_pkt_cnt", 74'(rx_pkt_cnt), 74'd0);
    chk("reset_drop_cnt", 74'(rx_drop_cnt), 74'd0);
    eth_rst = 1'b0;
    @(negedge eth_clk);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'h3005, 12, 1, 0, 0, 0, 0, -1, 0);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, CMD, 8, 1, 0, 0, 0, 0, -1, 1);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP ^ 32'h1, 16'h3000, 16, 1, 0, 0, 0, 0, -1, 0);
    run_frame(MAC, 16'h86DD, 8'h45, 8'd17, IP, 16'h3000, 16, 1, 0, 0, 0, 0, -1, 0);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'h3001, 24, 1, 1, 0, 0, 0, -1, 0);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'h3001, 24, 1, 0, 0, 0, 0, -1, 0);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'h300F, 20, 0, 0, 0, 0, 0, -1, 0);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, CMD, 16, 0, 0, 0, 0, 0, -1, 0);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, CFG, 8, 1, 0, 0, 0, 0, -1, 1);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'h2FFF, 8, 1, 0, 0, 0, 0, -1, 0);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'h3002, 0, 1, 0, 0, 0, 0, -1, 0);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'h3002, 16, 1, 0, 0, 0, 4, -1, 0);
    run_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h45, 8'd17, IP, 16'h3003, 8, 1, 0, 0, 0, 0, -1, 0);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'h3004, 24, 1, 0, 0, 0, 0, 6, 0);
    run_frame(MAC, 16'h0800, 8'h45, 8'd17, IP, 16'h3004, 8, 1, 0, 0, 0, 0, -1, 0);
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(5);
      dst  = ($urandom_range(7) == 0) ? 48'hFFFF_FFFF_FFFF : MAC;
      et   = 16'h0800;
      vi   = 8'h45;
      pr   = 8'd17;
      da   = IP;
      lim  = 0;
      dp   = 16'h3000 + 16'($urandom_range(15));
      plen = 4 * $urandom_range(1, 16);
      if (kind == 1 || kind == 2) begin
        dp   = kind == 1 ? CMD : CFG;
        plen = $urandom_range(1, 24);
      end
      if (kind == 3) begin
        fld = $urandom_range(4);
        if (fld == 0) dst = MAC ^ 48'h1;
        if (fld == 1) et = 16'h0806;
        if (fld == 2) vi = 8'h46;
        if (fld == 3) pr = 8'd6;
        if (fld == 4) da = IP + 32'd1;
      end
      if (kind == 4) dp = ($urandom_range(1) == 0) ? 16'h2FFF : 16'h3012 + 16'($urandom_range(200));
      if (kind == 5) lim = $urandom_range(1, 6);
      run_frame(dst, et, vi, pr, da, dp, plen, $urandom_range(7) != 0, $urandom_range(4) == 0,
                $urandom_range(4) == 0, $urandom_range(4) == 0, lim, -1, 0);
    end
    repeat (4) @(negedge eth_clk);
    chk("tlp_q_empty", 74'(exp_tlp_q.size()), 74'd0);
    chk("cmd_q_empty", 74'(exp_cmd_q.size()), 74'd0);
    chk("cfg_q_empty", 74'(exp_cfg_q.size()), 74'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
